run_controller: RTL and testbench
=================================

Name: run_controller

Overview:
- Sequences the processor core for a host using the 4-phase req/done handshake.
- On request:
  - latches a program selector;
  - loads the core's PC with that program's start address;
  - runs the core until it halts or a cycle budget expires;
  - reports done, a cycle count and a timeout flag.
- Sits between the top-level req/done pins and the core's fetch/PC logic; top_level instantiates it.

Parameters:
- D, 12, PC / instruction-address width (matches core).
- P, 2, program-selector width (2**P start-address slots).
- C, 16, cycle-counter width.
- MAX_CYCLES, 4096, RUN-cycle budget before timeout; must satisfy 1 <= MAX_CYCLES <= 2**C-1.

Ports:
- clk  in  1  single system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- req  in  1  host run request, level; 4-phase handshake with done.
- prog_sel  in  P  program slot; sampled only on IDLE->INIT.
- core_halt  in  1  core has executed its halt instruction (level, valid while core_run=1).
- core_init  out  1  one-cycle pulse; core loads PC <= init_pc, clears its halt flag.
- init_pc  out  D  start address for the selected program (valid while core_init=1, 0 otherwise).
- core_run  out  1  core may fetch/execute this cycle; 0 = stalled.
- busy  out  1  high in INIT and RUN.
- done  out  1  high in DONE.
- timeout  out  1  last run ended on budget expiry; sticky until next INIT.
- cycle_cnt  out  C  RUN cycles of the last/current run; holds after DONE.

Behaviour:
- Reset (reset=0, async assert, sync release):
  - state=IDLE;
  - core_init=0, init_pc=0, core_run=0, busy=0, done=0, timeout=0, cycle_cnt=0;
  - latched sel=0.
- States: IDLE, INIT, RUN, DONE; encoded as an enum in the package; all outputs registered or decoded from state.
- IDLE:
  - req=1 sampled -> latch prog_sel, go INIT.
  - req=0 -> stay.
- INIT (exactly 1 cycle):
  - core_init=1, init_pc=PROG_BASE[sel];
  - cycle_cnt<=0, timeout<=0;
  - -> RUN.
- RUN:
  - core_run=1; cycle_cnt increments by 1 every RUN cycle, including the cycle core_halt is seen.
  - core_halt=1 -> DONE, timeout stays 0.
  - Else if cycle_cnt==MAX_CYCLES-1 -> timeout<=1, DONE.
- Halt and budget expiry in the same cycle: halt wins, timeout=0.
- DONE:
  - done=1, core_run=0;
  - req=0 -> IDLE;
  - req=1 -> stay; a new run requires req to drop then rise.
- Latency, req rising edge sampled at edge k:
  - INIT occupies cycle k+1;
  - first RUN cycle is k+2;
  - done rises 1 cycle after the RUN cycle in which halt is sampled.
- req dropped during INIT/RUN: ignored; the run completes, done pulses high for exactly 1 cycle, then IDLE.
- prog_sel changes after IDLE->INIT have no effect on the current run.
- core_halt while not in RUN: ignored.
- cycle_cnt never wraps, bounded by MAX_CYCLES.
- Reset asserted mid-run: immediate return to IDLE with all outputs at reset values; no done is produced for the aborted run.

Decomposition:
- Package mcav_ctrl_pkg holds:
  - typedef enum run_state_t {IDLE, INIT, RUN, DONE};
  - localparam PROG_BASE[4] of D bits = {12'h000, 12'h100, 12'h200, 12'h300};
  - default MAX_CYCLES.
- Optional sub-module run_cycle_counter:
  - clear, enable, limit compare;
  - outputs count and at_limit.
- Remainder is a single FSM module.

Test Plan:
- Reset: drive reset=0 mid-simulation with random state -> all outputs 0, state IDLE asynchronously (before next clk edge).
- Basic run:
  - prog_sel=1, req=1; core model halts on its 20th RUN cycle;
  - expect core_init pulse with init_pc=12'h100 one cycle after req sampled;
  - expect done=1 with cycle_cnt=20, timeout=0;
  - drop req -> IDLE next cycle.
- Timeout:
  - MAX_CYCLES=64, core never halts;
  - expect done=1, timeout=1, cycle_cnt=64, core_run low from the DONE cycle on.
- Halt/timeout collision: halt exactly on RUN cycle 64 with MAX_CYCLES=64 -> timeout=0, cycle_cnt=64.
- Early req drop:
  - req falls during RUN;
  - expect run completes, done high exactly 1 cycle, then IDLE;
  - req held high in DONE keeps done=1 with no new run.
- Back-to-back runs:
  - prog_sel=3 then 0, with prog_sel toggled mid-run;
  - expect init_pc 12'h300 then 12'h000, timeout cleared at second INIT.
- Reset mid-RUN then req: the subsequent run starts cleanly with cycle_cnt from 0.

Source files
------------

// File: rtl/mcav_ctrl_pkg.sv
// Shared types and constants for the core run controller: FSM state encoding,
// per-slot program start addresses and the default run-cycle budget.
package mcav_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } run_state_t;

  localparam int unsigned PROG_AW        = 12;
  localparam int unsigned MAX_CYCLES_DEF = 4096;

  localparam logic [PROG_AW-1:0] PROG_BASE [4] = '{12'h000, 12'h100, 12'h200, 12'h300};

  // Slots beyond the table map to address 0 rather than indexing out of range.
  function automatic logic [PROG_AW-1:0] prog_base(input logic [31:0] slot);
    prog_base = (slot < 32'd4) ? PROG_BASE[slot[1:0]] : '0;
  endfunction

endpackage

// File: rtl/run_cycle_counter.sv
// RUN-cycle counter with synchronous clear and a budget-limit flag; clear wins
// over enable so a new run always starts from zero.
module run_cycle_counter #(
  parameter int unsigned C          = 16,
  parameter int unsigned MAX_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear_i,
  input  logic         en_i,
  output logic [C-1:0] count_o,
  output logic         at_limit_o
);

  logic [C-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i)      count_d = '0;
    else if (en_i)    count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o    = count_q;
  // The FSM leaves RUN on this cycle, so the count tops out at MAX_CYCLES.
  assign at_limit_o = (count_q == C'(MAX_CYCLES - 1));

endmodule

// File: rtl/run_controller.sv
// Host-facing run sequencer: on a 4-phase req/done handshake it initialises the
// core at the selected program, runs it to halt or budget expiry, and reports.
module run_controller
  import mcav_ctrl_pkg::*;
#(
  parameter int unsigned D          = 12,
  parameter int unsigned P          = 2,
  parameter int unsigned C          = 16,
  parameter int unsigned MAX_CYCLES = MAX_CYCLES_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req,
  input  logic [P-1:0] prog_sel,
  input  logic         core_halt,
  output logic         core_init,
  output logic [D-1:0] init_pc,
  output logic         core_run,
  output logic         busy,
  output logic         done,
  output logic         timeout,
  output logic [C-1:0] cycle_cnt
);

  run_state_t   state_q, state_d;
  logic [P-1:0] sel_q, sel_d;
  logic         timeout_q, timeout_d;
  logic         at_limit;

  run_cycle_counter #(
    .C          (C),
    .MAX_CYCLES (MAX_CYCLES)
  ) u_cnt (
    .clk        (clk),
    .rst_n      (reset),
    .clear_i    (state_q == INIT),
    .en_i       (state_q == RUN),
    .count_o    (cycle_cnt),
    .at_limit_o (at_limit)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          sel_d   = prog_sel;
          state_d = INIT;
        end
      end
      INIT: begin
        timeout_d = 1'b0;
        state_d   = RUN;
      end
      RUN: begin
        // Halt takes priority over budget expiry in the same cycle.
        if (core_halt) begin
          state_d = DONE;
        end else if (at_limit) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (!req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      timeout_q <= timeout_d;
    end
  end

  assign core_init = (state_q == INIT);
  assign init_pc   = (state_q == INIT) ? D'(prog_base(32'(sel_q))) : '0;
  assign core_run  = (state_q == RUN);
  assign busy      = (state_q == INIT) || (state_q == RUN);
  assign done      = (state_q == DONE);
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller: drives a small core model through
// halt, timeout, collision, early-drop, back-to-back and reset scenarios.
module tb_run_controller;

  localparam int D = 12;
  localparam int P = 2;
  localparam int C = 16;
  localparam int MAXC = 64;

  logic         clk;
  logic         reset;
  logic         req;
  logic [P-1:0] prog_sel;
  logic         core_halt;
  logic         core_init;
  logic [D-1:0] init_pc;
  logic         core_run;
  logic         busy;
  logic         done;
  logic         timeout;
  logic [C-1:0] cycle_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  run_controller #(.D(D), .P(P), .C(C), .MAX_CYCLES(MAXC)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .prog_sel  (prog_sel),
    .core_halt (core_halt),
    .core_init (core_init),
    .init_pc   (init_pc),
    .core_run  (core_run),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .cycle_cnt (cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: counts RUN cycles, raises halt on RUN cycle halt_at (0 = never),
  // optionally drops req / changes prog_sel mid-run. Returns at the first DONE negedge.
  task automatic drive_run(input int halt_at, input int drop_at, input int flip_at,
                           input logic [P-1:0] flip_val, output int runs,
                           output bit got_done, output logic [C-1:0] first_cnt,
                           output logic first_to);
    runs = 0; got_done = 1'b0; first_cnt = '0; first_to = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) begin
        core_halt = 1'b0;
        got_done  = 1'b1;
        break;
      end
      if (core_run) begin
        runs++;
        if (runs == 1) begin first_cnt = cycle_cnt; first_to = timeout; end
        if (runs == drop_at) req = 1'b0;
        if (runs == flip_at) prog_sel = flip_val;
        core_halt = (runs == halt_at);
      end else begin
        core_halt = 1'b0;
      end
    end
  endtask

  // Raises req with the given slot and checks the INIT cycle that follows.
  task automatic start_run(input logic [P-1:0] sel, input logic [D-1:0] exp_pc, input string tag);
    @(negedge clk);
    prog_sel = sel;
    req      = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (core_init !== 1'b1 || init_pc !== exp_pc || busy !== 1'b1 || core_run !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_init: core_init=%b init_pc=%h busy=%b core_run=%b, want 1 %h 1 0",
               tag, core_init, init_pc, busy, core_run, exp_pc);
    end
  endtask

  task automatic test_reset;
    #1;
    n_cmp++;
    if ({core_init, core_run, busy, done, timeout} !== 5'b0 || init_pc !== '0 || cycle_cnt !== '0) begin
      n_bad++;
      $display("FAIL reset_state: init=%b run=%b busy=%b done=%b to=%b pc=%h cnt=%0d, want all 0",
               core_init, core_run, busy, done, timeout, init_pc, cycle_cnt);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_basic;
    int runs; bit got; logic [C-1:0] fc; logic ft;
    start_run(2'd1, 12'h100, "basic");
    prog_sel = 2'd2;
    drive_run(20, 0, 0, 2'd0, runs, got, fc, ft);
    n_cmp++;
    if (!got || runs != 20 || cycle_cnt !== 16'd20 || timeout !== 1'b0 || core_run !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_done: got=%b runs=%0d cnt=%0d to=%b run=%b busy=%b, want 1 20 20 0 0 0",
               got, runs, cycle_cnt, timeout, core_run, busy);
    end
    n_cmp++;
    if (fc !== 16'd0) begin
      n_bad++;
      $display("FAIL basic_first_cnt: cnt=%0d, want 0", fc);
    end
    req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || cycle_cnt !== 16'd20) begin
      n_bad++;
      $display("FAIL basic_idle: done=%b busy=%b cnt=%0d, want 0 0 20", done, busy, cycle_cnt);
    end
    core_halt = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || core_init !== 1'b0) begin
      n_bad++;
      $display("FAIL halt_in_idle: busy=%b done=%b init=%b, want 0 0 0", busy, done, core_init);
    end
    core_halt = 1'b0;
  endtask

  task automatic test_timeout;
    int runs; bit got; logic [C-1:0] fc; logic ft;
    start_run(2'd2, 12'h200, "timeout");
    drive_run(0, 0, 0, 2'd0, runs, got, fc, ft);
    n_cmp++;
    if (!got || runs != 64 || cycle_cnt !== 16'd64 || timeout !== 1'b1 || core_run !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_done: got=%b runs=%0d cnt=%0d to=%b run=%b, want 1 64 64 1 0",
               got, runs, cycle_cnt, timeout, core_run);
    end
    for (int i = 0; i < 3; i++) @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || core_run !== 1'b0 || core_init !== 1'b0 || cycle_cnt !== 16'd64) begin
      n_bad++;
      $display("FAIL done_hold: done=%b busy=%b run=%b init=%b cnt=%0d, want 1 0 0 0 64",
               done, busy, core_run, core_init, cycle_cnt);
    end
    req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_collision;
    int runs; bit got; logic [C-1:0] fc; logic ft;
    start_run(2'd0, 12'h000, "collision");
    drive_run(64, 0, 0, 2'd0, runs, got, fc, ft);
    n_cmp++;
    if (!got || runs != 64 || cycle_cnt !== 16'd64 || timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL collision: got=%b runs=%0d cnt=%0d to=%b, want 1 64 64 0",
               got, runs, cycle_cnt, timeout);
    end
    req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_early_drop;
    int runs; bit got; logic [C-1:0] fc; logic ft;
    start_run(2'd2, 12'h200, "drop");
    drive_run(10, 5, 0, 2'd0, runs, got, fc, ft);
    n_cmp++;
    if (!got || runs != 10 || cycle_cnt !== 16'd10 || req !== 1'b0) begin
      n_bad++;
      $display("FAIL drop_done: got=%b runs=%0d cnt=%0d, want 1 10 10", got, runs, cycle_cnt);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL drop_pulse: done=%b busy=%b one cycle after done, want 0 0", done, busy);
    end
  endtask

  task automatic test_back_to_back;
    int runs; bit got; logic [C-1:0] fc; logic ft;
    start_run(2'd3, 12'h300, "b2b_a");
    drive_run(0, 0, 10, 2'd1, runs, got, fc, ft);
    n_cmp++;
    if (!got || timeout !== 1'b1 || cycle_cnt !== 16'd64) begin
      n_bad++;
      $display("FAIL b2b_a_done: got=%b to=%b cnt=%0d, want 1 1 64", got, timeout, cycle_cnt);
    end
    req = 1'b0;
    @(negedge clk);
    start_run(2'd0, 12'h000, "b2b_b");
    drive_run(7, 0, 0, 2'd0, runs, got, fc, ft);
    n_cmp++;
    if (fc !== 16'd0 || ft !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_b_start: cnt=%0d to=%b in first RUN cycle, want 0 0", fc, ft);
    end
    n_cmp++;
    if (!got || runs != 7 || cycle_cnt !== 16'd7 || timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_b_done: got=%b runs=%0d cnt=%0d to=%b, want 1 7 7 0", got, runs, cycle_cnt, timeout);
    end
    req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    int runs; bit got; logic [C-1:0] fc; logic ft;
    start_run(2'd1, 12'h100, "rst");
    for (int i = 0; i < 6; i++) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({core_init, core_run, busy, done, timeout} !== 5'b0 || init_pc !== '0 || cycle_cnt !== '0) begin
      n_bad++;
      $display("FAIL async_reset: init=%b run=%b busy=%b done=%b to=%b pc=%h cnt=%0d, want all 0",
               core_init, core_run, busy, done, timeout, init_pc, cycle_cnt);
    end
    req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL no_done_after_abort: done=%b busy=%b, want 0 0", done, busy);
    end
    start_run(2'd1, 12'h100, "post_rst");
    drive_run(3, 0, 0, 2'd0, runs, got, fc, ft);
    n_cmp++;
    if (!got || fc !== 16'd0 || runs != 3 || cycle_cnt !== 16'd3 || timeout !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset_run: got=%b first=%0d runs=%0d cnt=%0d to=%b, want 1 0 3 3 0",
               got, fc, runs, cycle_cnt, timeout);
    end
    req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset     = 1'b0;
    req       = 1'b0;
    prog_sel  = '0;
    core_halt = 1'b0;
    test_reset();
    test_basic();
    test_timeout();
    test_collision();
    test_early_drop();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
